// File: rtl/sweep_pkg.sv
// rtl/sweep_pkg.sv - shared state encoding, golden table and width helper for the truth-table sweeper
package sweep_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } sweep_state_e;

   // Golden table for s = ~x & y; bit i is the output for vector i
   localparam logic [3:0] F_XY_EXPECTED = 4'b0010;

   function automatic int settle_cnt_width(input int settle_cycles);
      if (settle_cycles < 1) begin
         return 1;
      end
      return $clog2(settle_cycles + 1);
   endfunction

endpackage

// File: rtl/sweep_settle_cnt.sv
// rtl/sweep_settle_cnt.sv - settle counter with load, enable and terminal-count flag
module sweep_settle_cnt #(
   parameter int MAX_COUNT = 1,
   parameter int CNT_W     = 1
) (
   input  logic clock,
   input  logic reset,
   input  logic load_i,
   input  logic en_i,
   output logic tc_o
);

   localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_COUNT);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   assign tc_o = (count_q == MAX_C);

   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = '0;
      end else if (en_i) begin
         count_d = tc_o ? '0 : count_q + 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/truth_table_sweeper.sv
// rtl/truth_table_sweeper.sv - steps a combinational block through all input vectors and captures its truth table
// Optional golden-table check and pass output enabled by macro SWEEP_CHECK_EN.
module truth_table_sweeper
   import sweep_pkg::*;
#(
   parameter int N_IN          = 2,
   parameter int SETTLE_CYCLES = 1
`ifdef SWEEP_CHECK_EN
   ,
   parameter logic [(1<<N_IN)-1:0] EXPECTED = F_XY_EXPECTED
`endif
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   start,
   input  logic                   dut_out,
   output logic [N_IN-1:0]        vec_out,
   output logic                   busy,
   output logic                   done,
`ifdef SWEEP_CHECK_EN
   output logic                   pass,
`endif
   output logic [(1<<N_IN)-1:0]   table_out
);

   localparam int              TW       = 1 << N_IN;
   localparam int              CNT_W    = settle_cnt_width(SETTLE_CYCLES);
   localparam logic [N_IN-1:0] VEC_LAST = '1;

   sweep_state_e    state_q, state_d;
   logic [N_IN-1:0] vec_q, vec_d;
   logic [TW-1:0]   table_q, table_d;
   logic            cnt_load, cnt_en, cnt_tc;

   sweep_settle_cnt #(
      .MAX_COUNT (SETTLE_CYCLES),
      .CNT_W     (CNT_W)
   ) u_settle (
      .clock  (clock),
      .reset  (reset),
      .load_i (cnt_load),
      .en_i   (cnt_en),
      .tc_o   (cnt_tc)
   );

   always_comb begin
      state_d  = state_q;
      vec_d    = vec_q;
      table_d  = table_q;
      cnt_load = 1'b0;
      cnt_en   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               table_d  = '0;
               vec_d    = '0;
               cnt_load = 1'b1;
               state_d  = ST_RUN;
            end
         end
         ST_RUN: begin
            cnt_en = 1'b1;
            // Sample on the last edge of the settle window; terminal vector holds into DONE
            if (cnt_tc) begin
               table_d[vec_q] = dut_out;
               if (vec_q == VEC_LAST) begin
                  state_d = ST_DONE;
               end else begin
                  vec_d = vec_q + 1'b1;
               end
            end
         end
         ST_DONE: begin
            vec_d   = '0;
            state_d = ST_IDLE;
         end
         default: begin
            vec_d   = '0;
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= ST_IDLE;
         vec_q   <= '0;
         table_q <= '0;
      end else begin
         state_q <= state_d;
         vec_q   <= vec_d;
         table_q <= table_d;
      end
   end

   assign vec_out   = vec_q;
   assign table_out = table_q;
   assign busy      = (state_q == ST_RUN);
   assign done      = (state_q == ST_DONE);

`ifdef SWEEP_CHECK_EN
   logic pass_q, pass_d;

   // Compare against table_d so the sample taken on the RUN->DONE edge is included
   always_comb begin
      pass_d = pass_q;
      if (state_q == ST_IDLE && start) begin
         pass_d = 1'b0;
      end else if (state_q == ST_RUN && cnt_tc && vec_q == VEC_LAST) begin
         pass_d = (table_d == EXPECTED);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         pass_q <= 1'b0;
      end else begin
         pass_q <= pass_d;
      end
   end

   assign pass = pass_q;
`endif

endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb/tb_truth_table_sweeper.sv - self-checking bench: three sweeper instances against a cycle-level model
module tb_truth_table_sweeper;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic reset, start;
   logic [1:0] vec0, vec1, vec2;
   logic       busy0, busy1, busy2, done0, done1, done2;
   logic [3:0] tbl0, tbl1, tbl2;
   logic       dout0, dout1, dout2;
   logic [1:0] dly_a, dly_b;
`ifdef SWEEP_CHECK_EN
   logic       pass0, pass1, pass2;
`endif

   // u0: s = ~x & y, default settle; u1: x & y, no settle; u2: ~x & y with 2-cycle output delay
   assign dout0 = ~vec0[1] & vec0[0];
   assign dout1 = vec1[1] & vec1[0];
   assign dout2 = ~dly_b[1] & dly_b[0];
   always @(posedge clock) begin
      dly_a <= vec2;
      dly_b <= dly_a;
   end

   truth_table_sweeper u0 (.clock(clock), .reset(reset), .start(start), .dut_out(dout0),
      .vec_out(vec0), .busy(busy0), .done(done0),
`ifdef SWEEP_CHECK_EN
      .pass(pass0),
`endif
      .table_out(tbl0));

   truth_table_sweeper #(.N_IN(2), .SETTLE_CYCLES(0)) u1 (.clock(clock), .reset(reset),
      .start(start), .dut_out(dout1), .vec_out(vec1), .busy(busy1), .done(done1),
`ifdef SWEEP_CHECK_EN
      .pass(pass1),
`endif
      .table_out(tbl1));

   truth_table_sweeper #(.N_IN(2), .SETTLE_CYCLES(3)) u2 (.clock(clock), .reset(reset),
      .start(start), .dut_out(dout2), .vec_out(vec2), .busy(busy2), .done(done2),
`ifdef SWEEP_CHECK_EN
      .pass(pass2),
`endif
      .table_out(tbl2));

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   // Model: kk = run edges since accept (-1 when idle); full = a complete table is being held
   int         sc[3]   = '{1, 0, 3};
   int         kk[3]   = '{-1, -1, -1};
   bit         full[3] = '{0, 0, 0};
   logic [3:0] fexp[3];
   localparam logic [3:0] GOLDEN = 4'b0010;

   always @(posedge clock) begin
      for (int i = 0; i < 3; i++) begin
         if (reset) begin
            kk[i] = -1;
            full[i] = 1'b0;
         end else if (kk[i] < 0) begin
            if (start) kk[i] = 0;
         end else begin
            kk[i]++;
            if (kk[i] > 4 * (sc[i] + 1)) begin
               kk[i] = -1;
               full[i] = 1'b1;
            end
         end
      end
   end

   bit         chk_en = 1'b0;
   int         busy_cnt[3], done_cnt[3];
   int         vq[$];
   logic [1:0] a_vec[3];
   logic       a_busy[3], a_done[3], a_pass[3];
   logic [3:0] a_tbl[3];

   always @(negedge clock) begin
      a_vec  = '{vec0, vec1, vec2};
      a_busy = '{busy0, busy1, busy2};
      a_done = '{done0, done1, done2};
      a_tbl  = '{tbl0, tbl1, tbl2};
`ifdef SWEEP_CHECK_EN
      a_pass = '{pass0, pass1, pass2};
`else
      a_pass = '{1'b0, 1'b0, 1'b0};
`endif
      if (chk_en) begin
         for (int i = 0; i < 3; i++) begin
            int         t;
            logic [1:0] e_vec;
            logic       e_busy, e_done, e_pass;
            logic [3:0] e_tbl;
            t = 4 * (sc[i] + 1);
            if (kk[i] < 0) begin
               e_vec = 0; e_busy = 0; e_done = 0;
               e_tbl = full[i] ? fexp[i] : 4'b0;
               e_pass = full[i] && (fexp[i] == GOLDEN);
            end else if (kk[i] < t) begin
               e_vec = 2'(kk[i] / (sc[i] + 1)); e_busy = 1; e_done = 0; e_pass = 0;
               e_tbl = 4'b0;
               for (int v = 0; v < 4; v++)
                  if ((v + 1) * (sc[i] + 1) <= kk[i]) e_tbl[v] = fexp[i][v];
            end else begin
               e_vec = 2'd3; e_busy = 0; e_done = 1; e_tbl = fexp[i];
               e_pass = (fexp[i] == GOLDEN);
            end
            chk($sformatf("u%0d_vec", i), 32'(a_vec[i]), 32'(e_vec));
            chk($sformatf("u%0d_busy", i), 32'(a_busy[i]), 32'(e_busy));
            chk($sformatf("u%0d_done", i), 32'(a_done[i]), 32'(e_done));
            chk($sformatf("u%0d_table", i), 32'(a_tbl[i]), 32'(e_tbl));
`ifdef SWEEP_CHECK_EN
            chk($sformatf("u%0d_pass", i), 32'(a_pass[i]), 32'(e_pass));
`endif
            if (a_busy[i]) busy_cnt[i]++;
            if (a_done[i]) done_cnt[i]++;
         end
         if (busy0) vq.push_back(int'(vec0));
      end
   end

   task automatic clear_stats();
      for (int i = 0; i < 3; i++) begin
         busy_cnt[i] = 0;
         done_cnt[i] = 0;
      end
      vq.delete();
   endtask

   task automatic pulse_start();
      @(posedge clock); #2 start = 1'b1;
      @(posedge clock); #2 start = 1'b0;
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) @(posedge clock);
      #2;
   endtask

   initial begin
      int seq[8];
      seq = '{0, 0, 1, 1, 2, 2, 3, 3};
      for (int v = 0; v < 4; v++) begin
         fexp[0][v] = ((v >> 1) == 0) && ((v & 1) == 1);
         fexp[1][v] = ((v >> 1) == 1) && ((v & 1) == 1);
         fexp[2][v] = fexp[0][v];
      end
      reset = 1'b1;
      start = 1'b0;
      @(posedge clock); #2 chk_en = 1'b1;
      @(posedge clock); #2 reset = 1'b0;
      chk("reset_table", 32'(tbl0), 32'h0);
      chk("model_f0", 32'(fexp[0]), 32'h2);
      chk("model_f1", 32'(fexp[1]), 32'h8);

      // Basic sweep on all three instances
      clear_stats();
      pulse_start();
      idle_cycles(20);
      chk("s1_tbl0", 32'(tbl0), 32'h2);
      chk("s1_tbl1", 32'(tbl1), 32'h8);
      chk("s1_tbl2", 32'(tbl2), 32'h2);
      chk("s1_busy0", 32'(busy_cnt[0]), 32'd8);
      chk("s1_busy1", 32'(busy_cnt[1]), 32'd4);
      chk("s1_busy2", 32'(busy_cnt[2]), 32'd16);
      chk("s1_done0", 32'(done_cnt[0]), 32'd1);
      chk("s1_done2", 32'(done_cnt[2]), 32'd1);
      chk("s1_vseq_len", 32'(vq.size()), 32'd8);
      for (int k = 0; k < 8 && k < vq.size(); k++)
         chk($sformatf("s1_vseq%0d", k), 32'(vq[k]), 32'(seq[k]));
`ifdef SWEEP_CHECK_EN
      chk("s1_pass0", 32'(pass0), 32'd1);
      chk("s1_pass1", 32'(pass1), 32'd0);
      chk("s1_pass2", 32'(pass2), 32'd1);
`endif

      // start during RUN (edge A+3) and during DONE of u0 (edge A+9)
      clear_stats();
      pulse_start();
      idle_cycles(2);
      start = 1'b1;
      @(posedge clock); #2 start = 1'b0;
      idle_cycles(5);
      start = 1'b1;
      @(posedge clock); #2 start = 1'b0;
      idle_cycles(20);
      chk("s2_done0", 32'(done_cnt[0]), 32'd1);
      chk("s2_busy0", 32'(busy_cnt[0]), 32'd8);
      chk("s2_done2", 32'(done_cnt[2]), 32'd1);
      chk("s2_tbl0", 32'(tbl0), 32'h2);

      // Reset on the 4th edge after accept
      clear_stats();
      pulse_start();
      idle_cycles(2);
      reset = 1'b1;
      @(posedge clock); #2;
      chk("s3_tbl0", 32'(tbl0), 32'h0);
      chk("s3_vec0", 32'(vec0), 32'h0);
      chk("s3_busy0", 32'(busy0), 32'h0);
      reset = 1'b0;
      idle_cycles(6);
      chk("s3_no_done", 32'(done_cnt[0] + done_cnt[1] + done_cnt[2]), 32'd0);
      clear_stats();
      pulse_start();
      idle_cycles(20);
      chk("s3_tbl0_after", 32'(tbl0), 32'h2);
      chk("s3_done0_after", 32'(done_cnt[0]), 32'd1);

      // start held high: back-to-back restarts from IDLE
      clear_stats();
      start = 1'b1;
      idle_cycles(30);
      start = 1'b0;
      idle_cycles(20);
      chk("s4_done0", 32'(done_cnt[0]), 32'd3);
      chk("s4_tbl2", 32'(tbl2), 32'h2);

      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
